nvram_sector_sync: RTL and testbench
====================================

NVRAM_SECTOR_SYNC -- requirements
Module: nvram_sector_sync

Interface
REQ-001 SHALL have parameter SECTOR_BITS, default 6, meaning log2 of the number of 512-byte backup-RAM sectors (NSEC = 2^SECTOR_BITS).
REQ-002 SHALL have parameter DIRTY_ONLY, default 1: 1 = a save writes only dirty sectors, 0 = a save writes all sectors.
REQ-003 SHALL have ports, in this order:
- clk_sys  in  1  system clock; all logic on rising edge.
- RESET_n  in  1  synchronous, active-low reset.
- bk_ena  in  1  writable save image mounted.
- load_req  in  1  level; rising edge requests a load.
- save_req  in  1  level; rising edge requests a save.
- autosave_en  in  1  autosave option.
- osd_open  in  1  OSD visible.
- download_done  in  1  one-cycle pulse at end of cart download.
- img_size_nz  in  1  mounted image has nonzero size.
- nvram_we  in  1  core writes backup RAM.
- nvram_a  in  SECTOR_BITS+9  core write address.
- sd_lba  out  32  sector number for the SD transfer.
- sd_rd  out  1  sector read request.
- sd_wr  out  1  sector write request.
- sd_ack  in  1  HPS transfer acknowledge, high for the duration of one sector.
- busy  out  1  transfer sequence active.
- loading  out  1  active sequence is a load; used to hold the core in reset.
- pending  out  1  at least one dirty sector.

Function
REQ-004 SHALL implement states IDLE, REQ (request raised, awaiting sd_ack rise), XFER (sd_ack high, awaiting fall) and DONE (one cycle, returns to IDLE).
REQ-005 SHALL register load_req, save_req and (pending & osd_open & autosave_en), each ANDed with bk_ena, and detect rising edges of these registered signals.
REQ-006 In IDLE, SHALL start a load on a load_req edge, or on download_done=1 with img_size_nz=1 and bk_ena=1.
REQ-007 In IDLE, SHALL start a save on a save_req edge or on an autosave edge.
REQ-008 On simultaneous load and save triggers, SHALL perform the load and discard the save.
REQ-009 SHALL ignore triggers outside IDLE; they are not queued.
REQ-010 A load SHALL transfer sectors 0..NSEC-1 in ascending order.
REQ-011 A save with DIRTY_ONLY=1 SHALL transfer, in ascending order, only the sectors whose dirty bit is set when the sector is selected.
REQ-012 A save with DIRTY_ONLY=1 and no dirty sectors SHALL go IDLE->DONE->IDLE, never assert sd_wr, and assert busy for exactly 2 cycles.
REQ-013 sd_lba SHALL equal the zero-extended current sector index.
REQ-014 On entering REQ, SHALL assert sd_rd (load) or sd_wr (save); both SHALL deassert in the cycle after sd_ack is first sampled high.
REQ-015 On a sampled falling edge of sd_ack in XFER: if the current sector is the last to transfer, SHALL go to DONE; otherwise SHALL select the next sector and reassert the request in the next cycle (REQ).
REQ-016 "Last to transfer" SHALL mean: for a load, index NSEC-1; for a dirty-only save, no dirty sector above the current index.
REQ-017 SHALL keep one dirty bit per sector: a cycle with nvram_we=1 and bk_ena=1 sets bit nvram_a[SECTOR_BITS+8:9].
REQ-018 SHALL clear a sector's dirty bit on the sd_ack fall that completes its save.
REQ-019 If nvram_we hits the same sector in that same cycle, the set SHALL win.
REQ-020 A completed load SHALL clear all dirty bits in DONE.
REQ-021 Writes received during a load SHALL still be cleared by the load's DONE.
REQ-022 pending SHALL be the OR of all dirty bits.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 loading SHALL be 1 from the start cycle through DONE of a load.
REQ-025 bk_ena falling during a sequence SHALL NOT abort it.
REQ-026 sd_ack pulses received in IDLE SHALL be ignored.

Reset
REQ-027 While RESET_n=0 at a clock edge, SHALL reach state IDLE with sd_rd=0, sd_wr=0, busy=0, loading=0, sd_lba=0, all dirty bits cleared and pending=0, including when reset occurs mid-transfer.
REQ-028 After RESET_n rises, SHALL not detect an edge on load_req or save_req if that input was already high during reset.

Verification
REQ-029 Load: bk_ena=1, load_req rises, HPS model answers each request with an 8-cycle sd_ack -> sd_rd and sd_lba step 0..63, loading=1 throughout, busy falls after the 64th ack, pending=0.
REQ-030 Dirty-only save: writes to 0x0000, 0x1234 and 0x7FFF, then save_req rises -> exactly 3 sd_wr with sd_lba 0, 9, 63; pending=0 afterwards.
REQ-031 Re-dirty: a write to sector 9 in the same cycle as its sd_ack fall -> pending stays 1 after the save completes.
REQ-032 Autosave: sector 5 dirty, autosave_en=1, osd_open rises -> a single sd_wr with sd_lba=5; with autosave_en=0 -> no transfer.
REQ-033 Clean save: save_req rises with no dirty sectors -> busy=1 for 2 cycles, no sd_wr.
REQ-034 Abort: RESET_n low while sd_ack is high at sector 3 of a load -> next cycle busy=0, sd_rd=0, loading=0; a later load restarts at sd_lba=0.

Source files
------------

// File: rtl/nvram_sector_sync.sv
// Backup-RAM sector synchroniser: tracks dirty 512-byte sectors and sequences
// SD sector reads (load) and writes (save) through the HPS request/ack handshake.
//
// state  | meaning
// S_IDLE | waiting for a load/save trigger
// S_REQ  | sd_rd/sd_wr raised, waiting for sd_ack to rise
// S_XFER | sd_ack high, waiting for it to fall
// S_DONE | one cycle wrap-up (load clears all dirty bits here)
module nvram_sector_sync #(
  parameter int SECTOR_BITS = 6,
  parameter int DIRTY_ONLY  = 1
) (
  input  logic                   clk_sys,
  input  logic                   RESET_n,
  input  logic                   bk_ena,
  input  logic                   load_req,
  input  logic                   save_req,
  input  logic                   autosave_en,
  input  logic                   osd_open,
  input  logic                   download_done,
  input  logic                   img_size_nz,
  input  logic                   nvram_we,
  input  logic [SECTOR_BITS+8:0] nvram_a,
  output logic [31:0]            sd_lba,
  output logic                   sd_rd,
  output logic                   sd_wr,
  input  logic                   sd_ack,
  output logic                   busy,
  output logic                   loading,
  output logic                   pending
);
  localparam int NSEC = 1 << SECTOR_BITS;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [SECTOR_BITS-1:0] sec_q, sec_d;
  logic                   is_load_q, is_load_d;
  logic                   sd_rd_q, sd_rd_d;
  logic                   sd_wr_q, sd_wr_d;
  logic [NSEC-1:0]        dirty_q, dirty_d;
  logic                   lreq_q, lreq_d, lreq_p_q, lreq_p_d;
  logic                   sreq_q, sreq_d, sreq_p_q, sreq_p_d;
  logic                   auto_q, auto_d, auto_p_q, auto_p_d;

  logic                   start_load, start_save, any_dirty, has_next, last_sec;
  logic [SECTOR_BITS-1:0] first_dirty, next_dirty, wr_sec;
  logic                   unused_addr_bits;

  assign any_dirty        = |dirty_q;
  assign wr_sec           = nvram_a[SECTOR_BITS+8:9];
  assign unused_addr_bits = ^nvram_a[8:0];

  assign lreq_d   = load_req & bk_ena;
  assign sreq_d   = save_req & bk_ena;
  assign auto_d   = any_dirty & osd_open & autosave_en & bk_ena;
  assign lreq_p_d = lreq_q;
  assign sreq_p_d = sreq_q;
  assign auto_p_d = auto_q;

  // A simultaneous save trigger is dropped in favour of the load.
  assign start_load = (state_q == S_IDLE) & RESET_n &
                      ((lreq_q & ~lreq_p_q) | (download_done & img_size_nz & bk_ena));
  assign start_save = (state_q == S_IDLE) & RESET_n & ~start_load &
                      ((sreq_q & ~sreq_p_q) | (auto_q & ~auto_p_q));

  always_comb begin
    first_dirty = '0;
    next_dirty  = '0;
    has_next    = 1'b0;
    for (int i = NSEC - 1; i >= 0; i--) begin
      if (dirty_q[i]) begin
        first_dirty = SECTOR_BITS'(i);
        if (i > int'(sec_q)) begin
          next_dirty = SECTOR_BITS'(i);
          has_next   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    if (is_load_q || DIRTY_ONLY == 0) last_sec = &sec_q;
    else                              last_sec = ~has_next;
  end

  always_comb begin
    state_d   = state_q;
    sec_d     = sec_q;
    is_load_d = is_load_q;
    sd_rd_d   = sd_rd_q;
    sd_wr_d   = sd_wr_q;
    case (state_q)
      S_IDLE: begin
        if (start_load) begin
          state_d   = S_REQ;
          sec_d     = '0;
          is_load_d = 1'b1;
          sd_rd_d   = 1'b1;
          sd_wr_d   = 1'b0;
        end else if (start_save) begin
          is_load_d = 1'b0;
          if (DIRTY_ONLY != 0 && !any_dirty) begin
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
            sec_d   = (DIRTY_ONLY != 0) ? first_dirty : '0;
            sd_rd_d = 1'b0;
            sd_wr_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (sd_ack) begin
          state_d = S_XFER;
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
        end
      end
      S_XFER: begin
        if (!sd_ack) begin
          if (last_sec) begin
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
            sec_d   = (is_load_q || DIRTY_ONLY == 0) ? sec_q + SECTOR_BITS'(1) : next_dirty;
            sd_rd_d = is_load_q;
            sd_wr_d = ~is_load_q;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Set beats the completing-save clear; a finished load wipes everything.
  always_comb begin
    dirty_d = dirty_q;
    if (state_q == S_XFER && !sd_ack && !is_load_q) dirty_d[sec_q] = 1'b0;
    if (nvram_we && bk_ena) dirty_d[wr_sec] = 1'b1;
    if (state_q == S_DONE && is_load_q) dirty_d = '0;
  end

  always_ff @(posedge clk_sys) begin
    if (!RESET_n) begin
      state_q   <= S_IDLE;
      sec_q     <= '0;
      is_load_q <= 1'b0;
      sd_rd_q   <= 1'b0;
      sd_wr_q   <= 1'b0;
      dirty_q   <= '0;
      // Edge history preset high so a request held through reset is not seen as new.
      lreq_q    <= 1'b1;
      lreq_p_q  <= 1'b1;
      sreq_q    <= 1'b1;
      sreq_p_q  <= 1'b1;
      auto_q    <= 1'b1;
      auto_p_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      sec_q     <= sec_d;
      is_load_q <= is_load_d;
      sd_rd_q   <= sd_rd_d;
      sd_wr_q   <= sd_wr_d;
      dirty_q   <= dirty_d;
      lreq_q    <= lreq_d;
      lreq_p_q  <= lreq_p_d;
      sreq_q    <= sreq_d;
      sreq_p_q  <= sreq_p_d;
      auto_q    <= auto_d;
      auto_p_q  <= auto_p_d;
    end
  end

  assign sd_lba  = {{(32 - SECTOR_BITS){1'b0}}, sec_q};
  assign sd_rd   = sd_rd_q;
  assign sd_wr   = sd_wr_q;
  assign busy    = (state_q != S_IDLE) | start_load | start_save;
  assign loading = ((state_q != S_IDLE) & is_load_q) | start_load;
  assign pending = any_dirty;

endmodule

// File: tb/tb_nvram_sector_sync.sv
// Bench for nvram_sector_sync: directed scenarios, an HPS ack responder and a
// sector-level model (dirty set + expected transfer queue) checked every cycle.
module tb_nvram_sector_sync;
  logic        clk_sys = 1'b0;
  logic        RESET_n, bk_ena, load_req, save_req, autosave_en, osd_open;
  logic        download_done, img_size_nz, nvram_we, sd_ack;
  logic [14:0] nvram_a;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, busy, loading, pending;

  int checks = 0;
  int failures = 0;

  // Model state: dirty sectors, expected requests (lba, +1000 for a write), observed requests.
  bit [63:0] m_dirty = '0;
  int        exp_q[$];
  int        obs_lba[$];
  int        n_rd = 0, n_wr = 0;
  bit        mon_en = 1'b0;
  bit        req_prev = 1'b0, ack_prev = 1'b0;
  bit        cur_active = 1'b0, cur_wr = 1'b0, clr_pending = 1'b0, do_clr = 1'b0;
  int        cur_lba = 0;
  int        e;

  nvram_sector_sync #(.SECTOR_BITS(6), .DIRTY_ONLY(1)) dut (
    .clk_sys(clk_sys), .RESET_n(RESET_n), .bk_ena(bk_ena), .load_req(load_req),
    .save_req(save_req), .autosave_en(autosave_en), .osd_open(osd_open),
    .download_done(download_done), .img_size_nz(img_size_nz), .nvram_we(nvram_we),
    .nvram_a(nvram_a), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .busy(busy), .loading(loading), .pending(pending)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic wr_nv(input logic [14:0] a);
    nvram_we = 1'b1;
    nvram_a  = a;
    tick(1);
    nvram_we = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (busy && c < 2000) begin
      tick(1);
      c++;
    end
    chk(name, busy, 0);
  endtask

  task automatic push_load();
    for (int i = 0; i < 64; i++) exp_q.push_back(i);
  endtask

  task automatic push_save();
    for (int i = 0; i < 64; i++) if (m_dirty[i]) exp_q.push_back(1000 + i);
  endtask

  function automatic int obs_at(input int k);
    return (k < obs_lba.size()) ? obs_lba[k] : -1;
  endfunction

  // HPS responder: each request answered with an 8-cycle sd_ack.
  initial begin
    sd_ack = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      if ((sd_rd || sd_wr) && !sd_ack) begin
        sd_ack = 1'b1;
        repeat (8) @(posedge clk_sys);
        #1;
        sd_ack = 1'b0;
      end
    end
  end

  // Per-cycle compare; model updates take effect from the next cycle.
  always @(negedge clk_sys) begin
    if (mon_en) begin
      do_clr      = clr_pending;
      clr_pending = 1'b0;
      chk("pending", pending, (m_dirty != 0) ? 1 : 0);
      chk("rd_wr_exclusive", sd_rd & sd_wr, 0);
      chk("req_implies_busy", (sd_rd | sd_wr) & ~busy, 0);
      chk("loading_implies_busy", loading & ~busy, 0);
      if (!RESET_n) begin
        m_dirty    = '0;
        cur_active = 1'b0;
      end else begin
        if ((sd_rd || sd_wr) && !req_prev) begin
          chk("req_expected", (exp_q.size() != 0) ? 1 : 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("req_lba", sd_lba, e % 1000);
            chk("req_is_write", {31'b0, sd_wr}, (e >= 1000) ? 1 : 0);
          end
          cur_active = 1'b1;
          cur_wr     = sd_wr;
          cur_lba    = int'(sd_lba[5:0]);
          if (sd_wr) n_wr++;
          else n_rd++;
          obs_lba.push_back(int'(sd_lba));
        end
        if (cur_active && ack_prev && !sd_ack) begin
          cur_active = 1'b0;
          if (cur_wr) m_dirty[cur_lba] = 1'b0;
          else if (exp_q.size() == 0) clr_pending = 1'b1;
        end
        if (nvram_we && bk_ena) m_dirty[nvram_a[14:9]] = 1'b1;
        if (do_clr) m_dirty = '0;
      end
    end
    req_prev = sd_rd | sd_wr;
    ack_prev = sd_ack;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ow, orr, oi, cnt, bad;
    bit seen, hit;
    RESET_n = 1'b0; bk_ena = 1'b1; load_req = 1'b0; save_req = 1'b0;
    autosave_en = 1'b0; osd_open = 1'b0; download_done = 1'b0; img_size_nz = 1'b0;
    nvram_we = 1'b0; nvram_a = '0;
    tick(3);
    RESET_n = 1'b1;
    tick(1);
    mon_en = 1'b1;

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_sd_rd", sd_rd, 0);
    chk("rst_sd_wr", sd_wr, 0);
    chk("rst_loading", loading, 0);
    chk("rst_sd_lba", sd_lba, 0);
    chk("rst_pending", pending, 0);

    // Full load
    orr = n_rd; oi = obs_lba.size();
    push_load();
    load_req = 1'b1;
    tick(2);
    chk("load_start_rd", sd_rd, 1);
    bad = 0; cnt = 0;
    while (busy && cnt < 2000) begin
      if (!loading) bad++;
      tick(1);
      cnt++;
    end
    chk("load_timeout", busy, 0);
    chk("load_loading_throughout", bad, 0);
    chk("load_rd_count", n_rd - orr, 64);
    chk("load_first_lba", obs_at(oi), 0);
    chk("load_last_lba", obs_at(oi + 63), 63);
    chk("load_pending", pending, 0);
    chk("load_queue_empty", exp_q.size(), 0);
    load_req = 1'b0;
    tick(2);

    // Dirty-only save of sectors 0, 9, 63
    wr_nv(15'h0000); wr_nv(15'h1234); wr_nv(15'h7FFF);
    chk("save_pending_before", pending, 1);
    ow = n_wr; oi = obs_lba.size();
    push_save();
    save_req = 1'b1;
    tick(2);
    wait_idle("save_timeout");
    chk("save_wr_count", n_wr - ow, 3);
    chk("save_lba0", obs_at(oi), 0);
    chk("save_lba1", obs_at(oi + 1), 9);
    chk("save_lba2", obs_at(oi + 2), 63);
    chk("save_pending_after", pending, 0);
    save_req = 1'b0;
    tick(2);

    // Re-dirty sector 9 on its own ack fall
    wr_nv(15'h1200); wr_nv(15'h2800);
    push_save();
    save_req = 1'b1;
    seen = 1'b0; hit = 1'b0;
    for (int c = 0; c < 400 && !hit; c++) begin
      @(posedge clk_sys);
      #2;
      if (sd_ack && sd_lba == 32'd9) seen = 1'b1;
      else if (seen && !sd_ack) begin
        nvram_we = 1'b1;
        nvram_a  = 15'h1200;
        @(posedge clk_sys);
        #1;
        nvram_we = 1'b0;
        hit = 1'b1;
      end
    end
    chk("redirty_hit", hit, 1);
    wait_idle("redirty_timeout");
    chk("redirty_pending", pending, 1);
    save_req = 1'b0;
    tick(2);
    push_save();
    save_req = 1'b1;
    tick(2);
    wait_idle("flush_timeout");
    chk("flush_pending", pending, 0);
    save_req = 1'b0;
    tick(2);

    // Autosave on osd_open rise
    autosave_en = 1'b1;
    wr_nv(15'h0A00);
    tick(2);
    ow = n_wr; oi = obs_lba.size();
    push_save();
    osd_open = 1'b1;
    tick(3);
    wait_idle("auto_timeout");
    chk("auto_wr_count", n_wr - ow, 1);
    chk("auto_lba", obs_at(oi), 5);
    chk("auto_pending", pending, 0);
    autosave_en = 1'b0;
    osd_open = 1'b0;
    wr_nv(15'h0A00);
    tick(2);
    ow = n_wr;
    osd_open = 1'b1;
    tick(20);
    chk("noauto_busy", busy, 0);
    chk("noauto_wr_count", n_wr - ow, 0);
    chk("noauto_pending", pending, 1);
    osd_open = 1'b0;
    tick(2);
    push_save();
    save_req = 1'b1;
    tick(2);
    wait_idle("auto_flush_timeout");
    save_req = 1'b0;
    tick(2);

    // Clean save: two busy cycles, no write
    ow = n_wr; cnt = 0;
    save_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      if (busy) cnt++;
    end
    chk("clean_busy_cycles", cnt, 2);
    chk("clean_wr_count", n_wr - ow, 0);
    save_req = 1'b0;
    tick(2);

    // Abort a load at sector 3 while sd_ack is high
    push_load();
    load_req = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 400 && !hit; c++) begin
      tick(1);
      if (sd_ack && sd_lba == 32'd3) hit = 1'b1;
    end
    chk("abort_reached_sector3", hit, 1);
    RESET_n = 1'b0;
    tick(1);
    chk("abort_busy", busy, 0);
    chk("abort_sd_rd", sd_rd, 0);
    chk("abort_loading", loading, 0);
    chk("abort_sd_lba", sd_lba, 0);
    exp_q.delete();
    RESET_n = 1'b1;
    tick(12);
    chk("held_req_no_restart", busy, 0);

    // Simultaneous load+save after abort: load wins, restarts at 0, clears dirty
    load_req = 1'b0;
    tick(3);
    wr_nv(15'h0400);
    orr = n_rd; ow = n_wr; oi = obs_lba.size();
    push_load();
    load_req = 1'b1;
    save_req = 1'b1;
    tick(50);
    wr_nv(15'h5000);
    chk("write_during_load", pending, 1);
    wait_idle("restart_timeout");
    chk("restart_first_lba", obs_at(oi), 0);
    chk("restart_rd_count", n_rd - orr, 64);
    chk("restart_no_save", n_wr - ow, 0);
    chk("restart_pending", pending, 0);
    load_req = 1'b0;
    save_req = 1'b0;
    tick(3);

    // download_done trigger with gating, bk_ena dropped mid-load
    download_done = 1'b1; img_size_nz = 1'b0;
    tick(1);
    download_done = 1'b0;
    tick(3);
    chk("dl_zero_size_busy", busy, 0);
    bk_ena = 1'b0; img_size_nz = 1'b1; download_done = 1'b1;
    tick(1);
    download_done = 1'b0;
    tick(3);
    chk("dl_no_bk_busy", busy, 0);
    bk_ena = 1'b1;
    tick(2);
    orr = n_rd;
    push_load();
    download_done = 1'b1;
    tick(1);
    download_done = 1'b0;
    chk("dl_start_busy", busy, 1);
    tick(30);
    bk_ena = 1'b0;
    tick(30);
    bk_ena = 1'b1;
    wait_idle("dl_timeout");
    chk("dl_rd_count", n_rd - orr, 64);
    chk("dl_queue_empty", exp_q.size(), 0);
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
